rca_result_fifo: RTL and testbench

RCA_RESULT_FIFO -- requirements
Module: rca_result_fifo

---
 rtl/rca_result_fifo_pkg.sv | 12 +
 rtl/rca_result_fifo.sv | 86 ++++++++
 tb/tb_rca_result_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rca_result_fifo_pkg.sv
// Shared adder-side constants: FIFO depth default, pointer sizing, carry counter width.
package rca_result_fifo_pkg;

   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned CARRY_CNT_W    = 16;

   // Pointer width for a power-of-two FIFO depth
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/rca_result_fifo.sv
// Result FIFO behind the ripple-carry adder: buffers {cout,sum} words and counts carries.
// in_data is fed directly from rca_parameterized.final_sum by the enclosing level.
module rca_result_fifo
   import rca_result_fifo_pkg::*;
#(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          in_valid,
   input  logic [N:0]                    in_data,
   output logic                          in_ready,
   output logic                          out_valid,
   output logic [N:0]                    out_data,
   input  logic                          out_ready,
   output logic [ptr_width(DEPTH):0]     count,
   output logic [CARRY_CNT_W-1:0]        carry_cnt
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [N:0]             mem_q [DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [CARRY_CNT_W-1:0] carry_q, carry_d;
   logic                   wr_en;
   logic                   rd_en;

   // Handshake flags derive only from registered occupancy
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != CW'(0));
   assign out_data  = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign carry_cnt = carry_q;

   assign wr_en = in_valid && in_ready;
   assign rd_en = out_valid && out_ready;

   // Next-state for pointers, occupancy and carry counter; clr wins over traffic
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      carry_d  = carry_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         carry_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
         unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (wr_en && in_data[N] && (carry_q != '1)) carry_d = carry_q + CARRY_CNT_W'(1);
      end
   end

   // Control state with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         carry_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         carry_q  <= carry_d;
      end
   end

   // Storage array, not reset; a flushed or reset cycle never writes it
   always_ff @(posedge clk) begin
      if (wr_en && !clr && !rst) mem_q[wr_ptr_q] <= in_data;
   end

endmodule

// File: tb/tb_rca_result_fifo.sv
// Directed bench for rca_result_fifo (N=4, DEPTH=4) with a queue scoreboard.
module tb_rca_result_fifo;

   localparam int unsigned N     = 4;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic [N:0] in_data = '0;
   logic       in_ready;
   logic       out_valid;
   logic [N:0] out_data;
   logic       out_ready = 1'b0;
   logic [2:0] count;
   logic [15:0] carry_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [N:0] exp_q [$];
   int mcount = 0;
   int mcarry = 0;

   rca_result_fifo #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .count(count), .carry_cnt(carry_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pop the scoreboard whenever the DUT hands over its head word
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && !clr) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got %0h expected none", out_data);
         end else begin
            logic [N:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               n_fail++;
               $display("FAIL pop_data: got %0h expected %0h", out_data, e);
            end
         end
      end
   end

   task automatic check_model(input string tag);
      chk({tag, "_count"}, 32'(count), 32'(mcount));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(mcount != DEPTH));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(mcount != 0));
      chk({tag, "_carry"}, 32'(carry_cnt), 32'(mcarry));
   endtask

   // One cycle: drive at posedge+1, let the edge happen, update model and check
   task automatic step(input logic v, input logic [N:0] d, input logic r, input logic c);
      logic acc, pop;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      clr       = c;
      acc = v && (mcount != DEPTH) && !c;
      pop = r && (mcount != 0) && !c;
      if (acc) exp_q.push_back(d);
      @(posedge clk);
      #1;
      if (c) begin
         mcount = 0;
         mcarry = 0;
         exp_q.delete();
      end else begin
         mcount = mcount + (acc ? 1 : 0) - (pop ? 1 : 0);
         if (acc && d[N] && mcarry != 65535) mcarry++;
      end
      in_valid = 1'b0;
      clr      = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_carry", 32'(carry_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 5+9 into empty: no bypass, visible one edge later
      in_valid = 1'b1; in_data = 5'b01110; #1;
      chk("no_bypass_valid", 32'(out_valid), 32'd0);
      step(1'b1, 5'b01110, 1'b0, 1'b0);
      chk("w1_valid", 32'(out_valid), 32'd1);
      chk("w1_data", 32'(out_data), 32'h0E);
      chk("w1_carry", 32'(carry_cnt), 32'd0);

      // 10+10+1 sets the carry counter
      step(1'b1, 5'b10101, 1'b0, 1'b0);
      chk("w2_carry", 32'(carry_cnt), 32'd1);
      chk("w2_count", 32'(count), 32'd2);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_valid", 32'(out_valid), 32'd0);
      // out_ready on empty is ignored
      step(1'b0, '0, 1'b1, 1'b0);
      check_model("empty_pop");

      // Fill to full, then a write alongside a pop is refused
      step(1'b1, 5'h01, 1'b0, 1'b0);
      step(1'b1, 5'h12, 1'b0, 1'b0);
      step(1'b1, 5'h03, 1'b0, 1'b0);
      step(1'b1, 5'h14, 1'b0, 1'b0);
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_carry", 32'(carry_cnt), 32'd3);
      step(1'b1, 5'h1F, 1'b1, 1'b0);
      chk("refused_count", 32'(count), 32'd3);
      chk("refused_carry", 32'(carry_cnt), 32'd3);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      check_model("after_full");

      // Continuous write+pop across pointer wrap
      step(1'b1, 5'h0A, 1'b0, 1'b0);
      step(1'b1, 5'h0B, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 5'(i), 1'b1, 1'b0);
         chk("stream_count", 32'(count), 32'd2);
      end
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check_model("after_stream");

      // Asynchronous reset with three words queued
      step(1'b1, 5'h11, 1'b0, 1'b0);
      step(1'b1, 5'h02, 1'b0, 1'b0);
      step(1'b1, 5'h13, 1'b0, 1'b0);
      chk("pre_rst_count", 32'(count), 32'd3);
      rst = 1'b1;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_carry", 32'(carry_cnt), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      exp_q.delete();
      mcount = 0;
      mcarry = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      step(1'b1, 5'h15, 1'b0, 1'b0);
      chk("post_rst_count", 32'(count), 32'd1);
      chk("post_rst_data", 32'(out_data), 32'h15);
      step(1'b0, '0, 1'b1, 1'b0);

      // clr with a concurrent write at count 2 drops everything
      step(1'b1, 5'h16, 1'b0, 1'b0);
      step(1'b1, 5'h07, 1'b0, 1'b0);
      chk("pre_clr_count", 32'(count), 32'd2);
      step(1'b1, 5'h1C, 1'b0, 1'b1);
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_valid", 32'(out_valid), 32'd0);
      chk("clr_carry", 32'(carry_cnt), 32'd0);
      step(1'b1, 5'h09, 1'b0, 1'b0);
      chk("post_clr_head", 32'(out_data), 32'h09);
      step(1'b0, '0, 1'b1, 1'b0);
      check_model("final");

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
